// File: rtl/mux32_8x1.sv
// Eight-way WIDTH-bit selector built as a three-level tree of 2:1 gate-level mux cells,
// with a combinational output Y and a registered copy Q that clears on synchronous reset.
module mux32_8x1 #(
    parameter int unsigned WIDTH = 32
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic [2:0]       S,
    input  logic             CLK,
    input  logic             RST,
    output logic [WIDTH-1:0] Q
);

    logic [7:0][WIDTH-1:0] in_vec;
    logic [3:0][WIDTH-1:0] lvl1;
    logic [1:0][WIDTH-1:0] lvl2;
    logic [WIDTH-1:0]      lvl3;
    logic [2:0]            sel_n;

    assign in_vec = {I7, I6, I5, I4, I3, I2, I1, I0};
    assign sel_n  = ~S;

    // One 1-bit NOT/AND/OR mux cell per bit per tree node; bit b only ever sees bit b.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        for (genvar m = 0; m < 4; m++) begin : g_lvl1
            assign lvl1[m][b] = (sel_n[0] & in_vec[2*m][b]) | (S[0] & in_vec[2*m+1][b]);
        end
        for (genvar m = 0; m < 2; m++) begin : g_lvl2
            assign lvl2[m][b] = (sel_n[1] & lvl1[2*m][b]) | (S[1] & lvl1[2*m+1][b]);
        end
        assign lvl3[b] = (sel_n[2] & lvl2[0][b]) | (S[2] & lvl2[1][b]);
    end

    assign Y = lvl3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else begin
            Q <= Y;
        end
    end

endmodule

// File: tb/tb_mux32_8x1.sv
// Directed and randomised checks of the 8:1 selector output Y and its registered copy Q.
module tb_mux32_8x1;

    localparam int unsigned WIDTH = 32;

    logic [WIDTH-1:0] Y, Q;
    logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
    logic [2:0]       S;
    logic             CLK;
    logic             RST;

    logic [WIDTH-1:0] iv [8];
    logic [WIDTH-1:0] y_exp;
    int               n_checks = 0;
    int               n_errors = 0;

    mux32_8x1 #(.WIDTH(WIDTH)) dut (
        .Y   (Y),
        .I0  (I0),
        .I1  (I1),
        .I2  (I2),
        .I3  (I3),
        .I4  (I4),
        .I5  (I5),
        .I6  (I6),
        .I7  (I7),
        .S   (S),
        .CLK (CLK),
        .RST (RST),
        .Q   (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        I0 = iv[0]; I1 = iv[1]; I2 = iv[2]; I3 = iv[3];
        I4 = iv[4]; I5 = iv[5]; I6 = iv[6]; I7 = iv[7];
    endtask

    initial begin
        // All zero, reset for one edge
        for (int k = 0; k < 8; k++) iv[k] = '0;
        drive_inputs();
        S   = 3'b000;
        RST = 1'b1;
        #1;
        check("zero_y", Y, 32'h0000_0000);
        @(posedge CLK); #1;
        check("reset_q", Q, 32'h0000_0000);
        @(negedge CLK);
        RST = 1'b0;

        // Lower half sweep
        iv[0] = 32'h0001_2340; iv[1] = 32'habc2_1000;
        iv[2] = 32'h0003_3300; iv[3] = 32'h00aa_dd00;
        iv[4] = 32'h4444_4444; iv[5] = 32'h5555_5555;
        iv[6] = 32'h6666_6666; iv[7] = 32'h7777_7777;
        drive_inputs();
        S = 3'b000; #1; check("sweep_s0", Y, 32'h0001_2340);
        S = 3'b001; #1; check("sweep_s1", Y, 32'habc2_1000);
        S = 3'b010; #1; check("sweep_s2", Y, 32'h0003_3300);
        S = 3'b011; #1; check("sweep_s3", Y, 32'h00aa_dd00);

        // Upper half, Q one edge later
        iv[0] = 32'h0; iv[1] = 32'h1; iv[2] = 32'h2; iv[3] = 32'h3;
        drive_inputs();
        @(negedge CLK); S = 3'b100; #1; check("upper_y4", Y, 32'h4444_4444);
        @(posedge CLK); #1; check("upper_q4", Q, 32'h4444_4444);
        @(negedge CLK); S = 3'b101; #1; check("upper_y5", Y, 32'h5555_5555);
        @(posedge CLK); #1; check("upper_q5", Q, 32'h5555_5555);
        @(negedge CLK); S = 3'b110; #1; check("upper_y6", Y, 32'h6666_6666);
        @(posedge CLK); #1; check("upper_q6", Q, 32'h6666_6666);
        @(negedge CLK); S = 3'b111; #1; check("upper_y7", Y, 32'h7777_7777);
        @(posedge CLK); #1; check("upper_q7", Q, 32'h7777_7777);

        // Unselected inputs must not disturb Y
        @(negedge CLK);
        S = 3'b001; iv[1] = 32'hffff_ffff;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 8; k++) if (k != 1) iv[k] = $urandom;
            drive_inputs();
            #1;
            check("unsel_hold", Y, 32'hffff_ffff);
        end

        // Mid-cycle reset only takes effect at the next edge
        iv[7] = 32'h7777_7777;
        drive_inputs();
        S = 3'b111;
        @(posedge CLK); #1; check("rst_pre_q", Q, 32'h7777_7777);
        @(negedge CLK); RST = 1'b1; #1;
        check("rst_mid_q", Q, 32'h7777_7777);
        @(posedge CLK); #1;
        check("rst_edge_q", Q, 32'h0000_0000);
        check("rst_edge_y", Y, 32'h7777_7777);
        @(negedge CLK); RST = 1'b0; #1;
        check("rst_rel_q", Q, 32'h0000_0000);
        @(posedge CLK); #1; check("rst_after_q", Q, 32'h7777_7777);

        // Random data, every select code
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 100; v++) begin
                @(negedge CLK);
                for (int k = 0; k < 8; k++) iv[k] = $urandom;
                drive_inputs();
                S     = 3'(s);
                y_exp = iv[s];
                #1;
                check("rand_y", Y, y_exp);
                @(posedge CLK); #1;
                check("rand_q", Q, y_exp);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux32_8x1.md
MUX32_8X1 -- requirements
Module: mux32_8x1

Interface
REQ-001 Parameter: WIDTH, default 32 (`DATA_INDEX_LIMIT+1`), data path width of every data input and output.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: CLK  input  1  sole clock, rising-edge active.
REQ-004 Port: RST  input  1  synchronous active-high reset; affects only the registered output.
REQ-005 Port: Y  output  WIDTH  combinational selected data.
REQ-006 Port: I0..I7  input  WIDTH each  eight data candidates, index = select code.
REQ-007 Port: S  input  3  select code; S[2] is MSB.
REQ-008 Port: Q  output  WIDTH  registered copy of Y.
REQ-009 Port order SHALL be Y, I0, I1, I2, I3, I4, I5, I6, I7, S, CLK, RST, Q, so existing positional instantiations (Y, I0..I7, S) stay valid.

Function
REQ-010 Y SHALL equal In where n = S (unsigned), for S = 000..111, bit-for-bit across all WIDTH bits.
REQ-011 Y SHALL be purely combinational: zero clock latency, no dependence on CLK or RST.
REQ-012 Y SHALL update whenever S or the selected input changes; changes on unselected inputs SHALL NOT disturb Y.
REQ-013 Implementation SHALL be a tree of 2:1 multiplexers: level 1 selects on S[0] (I0/I1, I2/I3, I4/I5, I6/I7), level 2 on S[1], level 3 on S[2].
REQ-014 Each 2:1 stage SHALL be built from a 1-bit 2:1 mux cell replicated WIDTH times (gate-level: NOT, AND, OR).
REQ-015 No arithmetic, no width extension or truncation: every bit i of Y SHALL come only from bit i of the selected input.
REQ-016 Q SHALL capture Y on each rising CLK edge; latency from S/In change to Q is one cycle.
REQ-017 Q SHALL hold its value between rising edges regardless of input activity.
REQ-018 If S contains X/Z, Y is don't-care; Q SHALL capture whatever Y presents (no special handling).
REQ-019 Simultaneous change of S and all inputs SHALL settle to the value defined by REQ-010 before the next rising edge.

Reset
REQ-020 When RST = 1 at a rising CLK edge, Q SHALL become all zeros, overriding Y.
REQ-021 When RST = 0 at a rising edge, Q SHALL load Y.
REQ-022 RST asserted or deasserted between edges SHALL have no effect on Q until the next rising edge.
REQ-023 RST SHALL never affect Y; Y remains valid during reset.
REQ-024 Q SHALL be undefined after power-up until the first rising edge with RST = 1.

Verification
REQ-025 All inputs 0, S=000 -> Y=00000000; RST=1 for one edge -> Q=00000000.
REQ-026 I0=00012340, I1=abc21000, I2=00033300, I3=00aadd00, I4=44444444, I5=55555555, I6=66666666, I7=77777777; sweep S=000..011 -> Y=00012340, abc21000, 00033300, 00aadd00 respectively.
REQ-027 I0..I3=00000000..00000003, I4..I7 as above; S=100,101,110,111 -> Y=44444444, 55555555, 66666666, 77777777; Q follows one edge later.
REQ-028 S=001, I1=ffffffff, then toggle I0 and I2..I7 randomly -> Y stays ffffffff.
REQ-029 Q=77777777 (S=111), assert RST mid-cycle -> Q unchanged until next rising edge, then 00000000 while Y stays 77777777; deassert -> Q=77777777 on following edge.
REQ-030 Exhaustive: random data, all 8 S codes x 100 vectors -> Y equals indexed input every vector, Q equals previous-cycle Y.
